// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ARMv4 ALU datapath. These are the
//                operation select encoding for the arithmetic unit and the
//                packed NZCV flag bundle consumed by the condition-check logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Arithmetic unit operation select
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // NZCV flag bundle, MSB first in the ARM CPSR order
    typedef struct packed {
        logic n;    // negative: result MSB
        logic z;    // zero: result == 0
        logic c;    // carry out / NOT borrow
        logic v;    // signed overflow
    } alu_flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/arith_adder.sv
`default_nettype none
// ============================================================================
//  Module      : arith_adder
//  Description : Combinational N-bit ripple-carry adder built from a chain of
//                full adders. Exposes the carry into the MSB alongside the
//                carry out so the caller can derive signed overflow.
//  Ports       : a, b   - N-bit addends
//                cin    - carry into bit 0
//                sum    - N-bit sum, modulo 2^N
//                cout   - carry out of bit N-1
//                c_msb  - carry into bit N-1
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    // w_carry[i] is the carry into bit i; w_carry[N] is the final carry out
    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < N; i++) begin : g_fa
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout  = w_carry[N];
    assign c_msb = w_carry[N-1];

endmodule : arith_adder
`default_nettype wire

// File: rtl/arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit
//  Description : Registered N-bit add/subtract unit with ARM-style carry and
//                NZCV flags. Results appear one cycle after the operands.
//                Subtraction is performed as a + ~b + 1, so cout is NOT borrow.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                in_valid           - operands/select valid this cycle
//                a, b               - N-bit operands
//                select             - 0 = ADD, 1 = SUB
//                out, out_valid     - registered result and its valid strobe
//                cout, zero,
//                negative, overflow - registered flags, coherent with out
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_unit
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         select,
    output logic         cout,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);

    logic         w_is_sub;
    logic [N-1:0] w_b_op;
    logic [N-1:0] w_sum;
    logic         w_cout;
    logic         w_c_msb;

    logic [N-1:0] out_d,       out_q;
    alu_flags_t   flags_d,     flags_q;
    logic         out_valid_d, out_valid_q;

    // SUB reuses the adder: invert b and inject the +1 through cin
    assign w_is_sub = (select == ALU_OP_SUB);
    assign w_b_op   = w_is_sub ? ~b : b;

    arith_adder #(
        .N (N)
    ) u_adder (
        .a     (a),
        .b     (w_b_op),
        .cin   (w_is_sub),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    always_comb begin
        out_d       = out_q;
        flags_d     = flags_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d     = w_sum;
            flags_d.n = w_sum[N-1];
            flags_d.z = (w_sum == '0);
            flags_d.c = w_cout;
            // Carry into the MSB differing from carry out means the signed
            // result does not fit; this holds for ADD and for a + ~b + 1.
            flags_d.v = w_c_msb ^ w_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cout      = flags_q.c;
    assign zero      = flags_q.z;
    assign negative  = flags_q.n;
    assign overflow  = flags_q.v;

endmodule : arith_unit
`default_nettype wire

// File: tb/tb_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_unit
//  Description : Self-checking bench for arith_unit (N = 8). The driver
//                pushes hand-computed expected results into a scoreboard
//                queue. A monitor pops one entry each time out_valid is seen
//                and checks both the contents and the cycle it arrived in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] out;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
        int           cyc;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         select;
    logic         cout;
    logic [N-1:0] out;
    logic         out_valid;
    logic         zero;
    logic         negative;
    logic         overflow;

    exp_t sbq[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    arith_unit #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .select    (select),
        .cout      (cout),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: compares every presented result against the scoreboard
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid === 1'b1) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: out_valid=1 out=%0d with no pending operation (cycle %0d)",
                         out, cyc);
            end else begin
                e = sbq.pop_front();
                if (out !== e.out || cout !== e.c || zero !== e.z ||
                    negative !== e.n || overflow !== e.v || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got out=%0d c=%b z=%b n=%b v=%b cyc=%0d, expected out=%0d c=%b z=%b n=%b v=%b cyc=%0d",
                             e.name, out, cout, zero, negative, overflow, cyc,
                             e.out, e.c, e.z, e.n, e.v, e.cyc);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: out_valid=%b at cycle %0d, expected a result (out=%0d)",
                     e.name, out_valid, cyc, e.out);
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    // Drive one valid operation and record its hand-computed result
    task automatic op(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic sel, input logic [N-1:0] eo, input logic ec,
                      input logic ez, input logic en, input logic ev);
        exp_t e;
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        select   = sel;
        e.out  = eo;
        e.c    = ec;
        e.z    = ez;
        e.n    = en;
        e.v    = ev;
        e.cyc  = cyc + 1;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Direct register check, used for reset and hold behaviour
    task automatic check_regs(input string name, input logic [N-1:0] eo, input logic ec,
                              input logic ez, input logic en, input logic ev,
                              input logic evalid);
        n_tests++;
        if (out !== eo || cout !== ec || zero !== ez || negative !== en ||
            overflow !== ev || out_valid !== evalid) begin
            n_fail++;
            $display("FAIL %s: got out=%0d c=%b z=%b n=%b v=%b valid=%b, expected out=%0d c=%b z=%b n=%b v=%b valid=%b",
                     name, out, cout, zero, negative, overflow, out_valid,
                     eo, ec, ez, en, ev, evalid);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'd11;
        b        = 8'd4;
        select   = 1'b0;

        // Reset wins over in_valid for two edges
        step(); check_regs("reset_cycle1", 8'd0, 0, 0, 0, 0, 0);
        step(); check_regs("reset_cycle2", 8'd0, 0, 0, 0, 0, 0);

        // Back-to-back directed vectors                 out  c  z  n  v
        op("add_11_4",    8'd11,  8'd4,   0, 8'd15,  0, 0, 0, 0); step();
        op("sub_11_4",    8'd11,  8'd4,   1, 8'd7,   1, 0, 0, 0); step();
        op("add_240_2",   8'd240, 8'd2,   0, 8'd242, 0, 0, 1, 0); step();
        op("sub_240_2",   8'd240, 8'd2,   1, 8'd238, 1, 0, 1, 0); step();
        op("add_255_1",   8'd255, 8'd1,   0, 8'd0,   1, 1, 0, 0); step();
        op("sub_4_11",    8'd4,   8'd11,  1, 8'd249, 0, 0, 1, 0); step();
        op("sub_9_9",     8'd9,   8'd9,   1, 8'd0,   1, 1, 0, 0); step();
        op("add_127_1",   8'd127, 8'd1,   0, 8'd128, 0, 0, 1, 1); step();
        op("sub_128_1",   8'd128, 8'd1,   1, 8'd127, 1, 0, 0, 1); step();

        // Idle: valid drops, result and flags hold
        in_valid = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        select   = 1'b0;
        step(); check_regs("hold_cycle1", 8'd127, 1, 0, 0, 1, 0);
        step(); check_regs("hold_cycle2", 8'd127, 1, 0, 0, 1, 0);

        // Second burst of four
        op("add_100_50",  8'd100, 8'd50,  0, 8'd150, 0, 0, 1, 1); step();
        op("sub_200_100", 8'd200, 8'd100, 1, 8'd100, 1, 0, 0, 1); step();
        op("sub_0_1",     8'd0,   8'd1,   1, 8'd255, 0, 0, 1, 0); step();
        op("add_3_5",     8'd3,   8'd5,   0, 8'd8,   0, 0, 0, 0); step();

        // Reset arriving while valid traffic is flowing discards the operation
        op("add_5_6",     8'd5,   8'd6,   0, 8'd11,  0, 0, 0, 0); step();
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'd100;
        b        = 8'd27;
        select   = 1'b0;
        step(); check_regs("reset_midstream", 8'd0, 0, 0, 0, 0, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(); check_regs("after_reset_idle", 8'd0, 0, 0, 0, 0, 0);

        // Recovery after reset
        op("add_1_1",     8'd1,   8'd1,   0, 8'd2,   0, 0, 0, 0); step();
        in_valid = 1'b0;
        step(); check_regs("final_hold", 8'd2, 0, 0, 0, 0, 0);
        step();

        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results never appeared, expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_arith_unit
`default_nettype wire

// File: doc/arith_unit.md
Name: arith_unit

Overview:
- Parameterised N-bit registered add/subtract unit for the ARMv4 ALU datapath.
- Computes a+b or a−b with ARM-style carry and NZCV-style flags; results are registered one cycle after the operands.
- Sits beside the logic unit inside the ALU; the ALU result mux selects between them.

Parameters:
- N, 8, operand/result width in bits (N ≥ 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/select valid this cycle.
- a  input  N  operand A (unsigned / two's complement).
- b  input  N  operand B.
- select  input  1  operation: 0 = ADD (a+b), 1 = SUB (a−b).
- cout  output  1  carry out. ADD: carry from bit N−1. SUB: NOT borrow, i.e. 1 when a ≥ b unsigned.
- out  output  N  result, modulo 2^N.
- out_valid  output  1  out/flags hold a new result.
- zero  output  1  out == 0.
- negative  output  1  out[N−1].
- overflow  output  1  signed overflow of the selected operation.

Behaviour:
- Reset: on a rising clk edge with rst=1, out=0, cout=0, zero=0, negative=0, overflow=0, out_valid=0. rst has priority over in_valid.
- Latency: exactly 1 cycle. On the edge where in_valid=1 and rst=0, register the result of the inputs sampled on that edge. out_valid=1 in the following cycle.
- in_valid=0: out_valid goes to 0 on the next edge. out, cout and the flags hold their last values.
- No backpressure. A new operation may be accepted every cycle (full throughput).
- ADD: {cout,out} = a + b + 0, computed at N+1 bits.
- SUB: computed as a + ~b + 1. cout is the carry out of that sum (1 = no borrow). a−b with a==b gives out=0, cout=1.
- Overflow:
  - ADD: a[N−1]==b[N−1] and out[N−1]!=a[N−1].
  - SUB: a[N−1]!=b[N−1] and out[N−1]!=a[N−1].
- zero and negative are derived from the registered result value and registered with it, so they are coherent with out.
- Wrap-around: results wrap modulo 2^N. No saturation.
- Reset mid-operation: an operation accepted on the same edge as rst=1 is discarded.
- No X-propagation tolerance is required. Outputs are defined only from reset onward.

Decomposition:
- Shared package alu_pkg:
  - select encoding constants ALU_OP_ADD=1'b0, ALU_OP_SUB=1'b1.
  - a typedef for the 4-bit flag bundle {N,Z,C,V} used by the condition-check logic.
- Sub-module arith_adder: combinational N-bit ripple-carry adder (a, b, cin → sum, cout, carry into MSB), built from a full-adder generate loop. arith_unit inverts b and drives cin=select. Overflow is computed as the carry into the MSB XOR the carry out.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=11, b=4 → out=0, all flags 0, out_valid=0.
- a=11, b=4, select=0, in_valid=1 → next cycle out=15, cout=0, zero=0, negative=0, overflow=0, out_valid=1. Then select=1 → out=7, cout=1.
- a=240, b=2: select=0 → out=242, cout=0, negative=1. select=1 → out=238, cout=1, negative=1, overflow=0.
- Boundaries:
  - a=255, b=1, ADD → out=0, cout=1, zero=1.
  - a=4, b=11, SUB → out=249, cout=0, negative=1.
  - a=9, b=9, SUB → out=0, zero=1, cout=1.
- Signed overflow:
  - a=127, b=1, ADD → out=128, overflow=1, negative=1.
  - a=128, b=1, SUB → out=127, overflow=1, cout=1.
- Throughput/hold:
  - Back-to-back valid ops for 4 cycles → each result appears exactly one cycle later.
  - Drop in_valid → out_valid=0 and out holds its last value.
  - Assert rst while valid traffic is flowing → the next cycle shows reset values.
